// File: rtl/dmx_angle_scheduler_pkg.sv
// dmx_pkg: shared definitions for the tracking-DMX angle datapath.
//   ANGLE_W / DMX_W   : angle (signed Q3.8) and DMX channel widths
//   PI_Q38 / NEG_PI_Q38 : +/-pi in Q3.8, the saturation bounds of the
//                         optional angle clamp (ANGLE_CLAMP_EN)
//   state_t           : scheduler FSM state
//   clamp_angle()     : saturate a Q3.8 angle to [-pi, +pi]
package dmx_pkg;

    localparam int ANGLE_W = 11;
    localparam int DMX_W   = 8;

    localparam logic signed [ANGLE_W-1:0] PI_Q38     = 11'sd804;
    localparam logic signed [ANGLE_W-1:0] NEG_PI_Q38 = -11'sd804;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic signed [ANGLE_W-1:0] a);
        if (a > PI_Q38) begin
            return PI_Q38;
        end else if (a < NEG_PI_Q38) begin
            return NEG_PI_Q38;
        end
        return a;
    endfunction

endpackage

// File: rtl/dmx_angle_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
//   req_valid [NUM_REQ] : requesters currently offering work
//   rr_ptr    [PTR_W]   : index that has highest priority this round
//   grant     [NUM_REQ] : one-hot grant (all-zero when nothing is valid)
//   grant_idx [PTR_W]   : binary index of the granted requester
//   grant_any           : some requester is granted
module rr_arbiter
    import dmx_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Scan starting at rr_ptr and wrap modulo NUM_REQ; the first valid
    // requester met wins, which bounds any requester's wait to NUM_REQ grants.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmx_angle_scheduler.sv
// dmx_angle_scheduler: time-shares one external range_shifter between
// NUM_REQ angle requesters and keeps one DMX channel register per requester.
//
// Configuration macro: ANGLE_CLAMP_EN -- when defined, the accepted angle is
// saturated to [-pi, +pi] (Q3.8) before it drives shift_in.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : [NUM_REQ] requester i offers an angle
//   req_angle    : [NUM_REQ*11] angle i at [11i+10:11i], signed Q3.8
//   req_ready    : [NUM_REQ] one-hot grant (combinational)
//   shift_in     : [11] registered angle to range_shifter.in
//   shift_out    : [8]  range_shifter.out, valid SHIFT_LATENCY edges later
//   chan_out     : [NUM_REQ*8] DMX value per requester, slot i at [8i+7:8i]
//   chan_update  : [NUM_REQ] one-cycle pulse when slot i is written
//   busy         : high while a transaction is in flight
//   fsm_state    : debug view of the FSM state
//   rr_ptr       : debug view of the round-robin pointer
//
// Handshake: a requester holds req_valid (and its angle) until it sees
// req_valid[i] & req_ready[i] at a rising edge; that edge is the accept.
// req_ready is only ever raised for one index, only in IDLE.
module dmx_angle_scheduler
    import dmx_pkg::*;
#(
    parameter int                 NUM_REQ       = 2,
    parameter int                 SHIFT_LATENCY = 1,
    parameter logic [DMX_W-1:0]   RESET_CHAN    = 8'd128,
    localparam int                PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ANGLE_W-1:0]         shift_in,
    input  logic [DMX_W-1:0]           shift_out,
    output logic [NUM_REQ*DMX_W-1:0]   chan_out,
    output logic [NUM_REQ-1:0]         chan_update,
    output logic                       busy,
    output state_t                     fsm_state,
    output logic [PTR_W-1:0]           rr_ptr
);

    localparam int CNT_W = $clog2(SHIFT_LATENCY + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   grant_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic               done;
    logic [ANGLE_W-1:0] angle_sel;
    logic [ANGLE_W-1:0] angle_lat;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        angle_sel = req_angle[int'(grant_idx)*ANGLE_W +: ANGLE_W];
`ifdef ANGLE_CLAMP_EN
        angle_lat = clamp_angle(angle_sel);
`else
        angle_lat = angle_sel;
`endif
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                accept    = grant_any;
                if (grant_any) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt reaching zero means shift_out now reflects shift_in.
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_in    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            rr_ptr      <= '0;
            chan_out    <= {NUM_REQ{RESET_CHAN}};
            chan_update <= '0;
        end else begin
            chan_update <= '0;
            if (accept) begin
                shift_in <= angle_lat;
                cnt_q    <= CNT_W'(SHIFT_LATENCY);
                grant_q  <= grant_idx;
                if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) begin
                chan_out[int'(grant_q)*DMX_W +: DMX_W] <= shift_out;
                chan_update[grant_q]                   <= 1'b1;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_dmx_angle_scheduler.sv
// Bench for dmx_angle_scheduler (default parameters: 2 requesters,
// shifter latency 1). Contains a stand-in range_shifter and a transaction
// level reference model (priority pointer, channel array, expected queue).
module tb_dmx_angle_scheduler;
    import dmx_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int LAT     = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ANGLE_W-1:0] req_angle;
    logic [NUM_REQ-1:0]         req_ready;
    logic [ANGLE_W-1:0]         shift_in;
    logic [DMX_W-1:0]           shift_out;
    logic [NUM_REQ*DMX_W-1:0]   chan_out;
    logic [NUM_REQ-1:0]         chan_update;
    logic                       busy;
    state_t                     fsm_state;
    logic                       rr_ptr;

    dmx_angle_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .SHIFT_LATENCY (LAT),
        .RESET_CHAN    (8'd128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_angle   (req_angle),
        .req_ready   (req_ready),
        .shift_in    (shift_in),
        .shift_out   (shift_out),
        .chan_out    (chan_out),
        .chan_update (chan_update),
        .busy        (busy),
        .fsm_state   (fsm_state),
        .rr_ptr      (rr_ptr)
    );

    // ---------------- reference functions ----------------
    // Stand-in shifter map: [-1024,1023] -> [0,255].
    function automatic logic [7:0] shaper(input logic [10:0] a);
        int v;
        v = int'($signed(a));
        return 8'((v >>> 3) + 128);
    endfunction

    function automatic logic [10:0] exp_shift(input logic [10:0] a);
`ifdef ANGLE_CLAMP_EN
        int v;
        v = int'($signed(a));
        if (v > 804) return 11'd804;
        if (v < -804) return 11'(-804);
`endif
        return a;
    endfunction

    // Stand-in range_shifter: one clock edge of latency.
    always_ff @(posedge clk) shift_out <= shaper(shift_in);

    // ---------------- model / scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    int         m_ptr  = 0;
    logic [7:0] m_chan [NUM_REQ];
    logic [7:0] exp_q[$];
    int         last_upd = 0;

    function automatic int model_grant(input logic [1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT in IDLE. Offers v/angles, follows the
    // whole transaction and returns the granted index (-1 if none).
    task automatic do_txn(input logic [1:0] v, input logic [10:0] a0,
                          input logic [10:0] a1, input bit hold, output int g);
        logic [10:0] ang [NUM_REQ];
        logic [10:0] s;
        logic [7:0]  e;
        logic        gi;
        ang[0]    = a0;
        ang[1]    = a1;
        req_valid = v;
        req_angle = {a1, a0};
        #1;
        g = model_grant(v);
        check("req_ready_idle", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check("busy_idle", 32'(busy), 32'd0);
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        gi = g[0];
        @(negedge clk);
        s = exp_shift(ang[g]);
        exp_q.push_back(shaper(s));
        m_ptr = (g + 1) % NUM_REQ;
        check("shift_in_accept", 32'(shift_in), 32'(s));
        check("busy_wait", 32'(busy), 32'd1);
        check("upd_early", 32'(chan_update), 32'd0);
        if (!hold) req_valid[gi] = 1'b0;
        req_angle = 22'($urandom);
        #1;
        check("req_ready_wait", 32'(req_ready), 32'd0);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("upd_early", 32'(chan_update), 32'd0);
            check("shift_in_hold", 32'(shift_in), 32'(s));
        end
        @(negedge clk);
        e = exp_q.pop_front();
        m_chan[g] = e;
        last_upd  = cyc;
        check("chan_update", 32'(chan_update), 32'd1 << g);
        check("chan0", 32'(chan_out[7:0]), 32'(m_chan[0]));
        check("chan1", 32'(chan_out[15:8]), 32'(m_chan[1]));
        check("busy_done", 32'(busy), 32'd0);
        check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        check("shift_in_stable", 32'(shift_in), 32'(s));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          g;
        int          prev;
        int          t0;
        logic [1:0]  v;
        m_chan[0] = 8'd128;
        m_chan[1] = 8'd128;

        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        repeat (3) @(negedge clk);
        check("rst_shift_in", 32'(shift_in), 32'd0);
        check("rst_chan", 32'(chan_out), 32'h8080);
        check("rst_upd", 32'(chan_update), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ptr", 32'(rr_ptr), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd0);

        // single request
        do_txn(2'b01, 11'b00011010110, 11'd0, 1'b0, g);
        check("single_grant", 32'(g), 32'd0);

        // contention: -pi on 0, +pi on 1, from pointer 1 -> reset first
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0; m_chan[0] = 8'd128; m_chan[1] = 8'd128;
        do_txn(2'b11, 11'b10011011100, 11'd804, 1'b0, g);
        check("cont_first", 32'(g), 32'd0);
        t0 = last_upd;
        do_txn(2'b10, 11'b10011011100, 11'd804, 1'b0, g);
        check("cont_second", 32'(g), 32'd1);
        check("cont_spacing", 32'(last_upd - t0), 32'd3);

        // fairness: both held valid for six transactions
        prev = 1;
        for (int i = 0; i < 6; i++) begin
            do_txn(2'b11, 11'($urandom), 11'($urandom), 1'b1, g);
            check("fair_alt", 32'(g), 32'(prev ^ 1));
            prev = g;
        end

        // clamp boundaries (identity without ANGLE_CLAMP_EN)
        do_txn(2'b01, 11'h3FF, 11'd0, 1'b0, g);
`ifdef ANGLE_CLAMP_EN
        check("clamp_pos", 32'(shift_in), 32'd804);
`else
        check("clamp_pos", 32'(shift_in), 32'h3FF);
`endif
        do_txn(2'b10, 11'd0, 11'h400, 1'b0, g);

        // reset one cycle after accept
        req_valid = 2'b01;
        req_angle = {11'd0, 11'h123};
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0; m_chan[0] = 8'd128; m_chan[1] = 8'd128;
        check("mid_rst_upd", 32'(chan_update), 32'd0);
        check("mid_rst_chan", 32'(chan_out), 32'h8080);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ptr", 32'(rr_ptr), 32'd0);
        @(negedge clk);
        check("mid_rst_upd2", 32'(chan_update), 32'd0);
        check("mid_rst_chan2", 32'(chan_out), 32'h8080);

        // randomized transactions
        for (int i = 0; i < 30; i++) begin
            v = 2'($urandom_range(0, 3));
            do_txn(v, 11'($urandom), 11'($urandom), 1'($urandom_range(0, 1)), g);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
